// File: rtl/line_fill_unit_if.sv
// Bundle of the miss-request, data-array port-B and memory signals of the
// line fill unit. The engine side uses the master modport; the cache
// controller, data array and memory model side uses the slave modport.
interface line_fill_unit_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 9,
    parameter int WORD_BITS   = 3,
    parameter int TAG_WIDTH   = 20
);
    localparam int LINE_WIDTH = DATA_WIDTH * (2 ** WORD_BITS);

    logic                           miss_valid;
    logic                           miss_ready;
    logic [INDEX_WIDTH-1:0]         miss_index;
    logic [TAG_WIDTH-1:0]           miss_tag;
    logic                           victim_dirty;
    logic [TAG_WIDTH-1:0]           victim_tag;

    logic [INDEX_WIDTH-1:0]         arr_addr_b;
    logic                           arr_we_b;
    logic [LINE_WIDTH-1:0]          arr_data_b;
    logic [LINE_WIDTH-1:0]          arr_q_b;

    logic                           mem_req_valid;
    logic                           mem_req_ready;
    logic                           mem_req_write;
    logic [TAG_WIDTH+INDEX_WIDTH-1:0] mem_req_addr;
    logic [DATA_WIDTH-1:0]          mem_wdata;
    logic                           mem_wvalid;
    logic                           mem_wready;
    logic [DATA_WIDTH-1:0]          mem_rdata;
    logic                           mem_rvalid;

    logic                           done;

    modport master (
        input  miss_valid, miss_index, miss_tag, victim_dirty, victim_tag,
        input  arr_q_b, mem_req_ready, mem_wready, mem_rdata, mem_rvalid,
        output miss_ready, arr_addr_b, arr_we_b, arr_data_b,
        output mem_req_valid, mem_req_write, mem_req_addr, mem_wdata, mem_wvalid,
        output done
    );

    modport slave (
        output miss_valid, miss_index, miss_tag, victim_dirty, victim_tag,
        output arr_q_b, mem_req_ready, mem_wready, mem_rdata, mem_rvalid,
        input  miss_ready, arr_addr_b, arr_we_b, arr_data_b,
        input  mem_req_valid, mem_req_write, mem_req_addr, mem_wdata, mem_wvalid,
        input  done
    );
endinterface

// File: rtl/line_fill_unit.sv
// Cache miss engine on the line-wide port B of the data array: optional
// writeback of a dirty victim line, then a beat-by-beat fill of the missing
// line and a single line-wide write into the array.
//
//  state       | meaning
//  ------------+---------------------------------------------------------
//  S_IDLE      | waiting for a miss request, miss_ready=1
//  S_WB_RD     | victim line read issued on port B (1-cycle latency)
//  S_WB_REQ    | writeback request offered to memory; victim captured on entry
//  S_WB_DATA   | streaming victim words to memory, word 0 first
//  S_FILL_REQ  | line read request offered to memory
//  S_FILL_DATA | collecting fill beats into the line buffer
//  S_FILL_WR   | one-cycle line write into the array
//  S_DONE      | one-cycle done pulse
module line_fill_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 9,
    parameter int WORD_BITS   = 3,
    parameter int TAG_WIDTH   = 20
) (
    input  logic              clk,
    input  logic              rst,
    line_fill_unit_if.master  bus
);
    localparam int WORDS = 2 ** WORD_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB_RD,
        S_WB_REQ,
        S_WB_DATA,
        S_FILL_REQ,
        S_FILL_DATA,
        S_FILL_WR,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [INDEX_WIDTH-1:0]             index_q;
    logic [TAG_WIDTH-1:0]               miss_tag_q;
    logic [TAG_WIDTH-1:0]               victim_tag_q;
    logic [WORD_BITS-1:0]               cnt;
    logic                               capture_q;
    logic [WORDS-1:0][DATA_WIDTH-1:0]   line_buf;
    logic                               last_beat;

    assign last_beat = &cnt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and all engine outputs
    always_comb begin
        state_nx          = state;
        bus.miss_ready    = 1'b0;
        bus.arr_addr_b    = '0;
        bus.arr_we_b      = 1'b0;
        bus.arr_data_b    = '0;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_write = 1'b0;
        bus.mem_req_addr  = '0;
        bus.mem_wdata     = '0;
        bus.mem_wvalid    = 1'b0;
        bus.done          = 1'b0;
        case (state)
            S_IDLE: begin
                bus.miss_ready = 1'b1;
                if (bus.miss_valid) begin
                    state_nx = bus.victim_dirty ? S_WB_RD : S_FILL_REQ;
                end
            end
            S_WB_RD: begin
                bus.arr_addr_b = index_q;
                state_nx       = S_WB_REQ;
            end
            S_WB_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_write = 1'b1;
                bus.mem_req_addr  = {victim_tag_q, index_q};
                if (bus.mem_req_ready) begin
                    state_nx = S_WB_DATA;
                end
            end
            S_WB_DATA: begin
                bus.mem_wvalid = 1'b1;
                bus.mem_wdata  = line_buf[cnt];
                if (bus.mem_wready && last_beat) begin
                    state_nx = S_FILL_REQ;
                end
            end
            S_FILL_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = {miss_tag_q, index_q};
                if (bus.mem_req_ready) begin
                    state_nx = S_FILL_DATA;
                end
            end
            S_FILL_DATA: begin
                if (bus.mem_rvalid && last_beat) begin
                    state_nx = S_FILL_WR;
                end
            end
            S_FILL_WR: begin
                bus.arr_we_b   = 1'b1;
                bus.arr_addr_b = index_q;
                bus.arr_data_b = line_buf;
                state_nx       = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Request latch, beat counter and line buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            index_q      <= '0;
            miss_tag_q   <= '0;
            victim_tag_q <= '0;
            cnt          <= '0;
            capture_q    <= 1'b0;
            line_buf     <= '0;
        end else begin
            // Array data for the victim read arrives the cycle after S_WB_RD
            capture_q <= (state == S_WB_RD);
            if (capture_q) begin
                line_buf <= bus.arr_q_b;
            end
            if (state == S_IDLE && bus.miss_valid) begin
                index_q      <= bus.miss_index;
                miss_tag_q   <= bus.miss_tag;
                victim_tag_q <= bus.victim_tag;
            end
            // Counter runs only inside a data phase, so it is zero on every phase entry
            case (state)
                S_WB_DATA: begin
                    if (bus.mem_wready) begin
                        cnt <= cnt + WORD_BITS'(1);
                    end
                end
                S_FILL_DATA: begin
                    if (bus.mem_rvalid) begin
                        line_buf[cnt] <= bus.mem_rdata;
                        cnt           <= cnt + WORD_BITS'(1);
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_line_fill_unit.sv
// Bench for line_fill_unit: directed misses with a scoreboard of expected
// memory requests, writeback beats, array line writes and done pulses.
module tb_line_fill_unit;
    localparam int DW = 32;
    localparam int IW = 9;
    localparam int WB = 3;
    localparam int TW = 20;
    localparam int LW = DW * (2 ** WB);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    line_fill_unit_if #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW), .WORD_BITS(WB), .TAG_WIDTH(TW)) bus ();

    line_fill_unit #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW), .WORD_BITS(WB), .TAG_WIDTH(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Data array model: registered read, line-wide write
    logic [LW-1:0] arr_mem [0:511];
    always @(posedge clk) begin
        bus.arr_q_b <= arr_mem[bus.arr_addr_b];
        if (bus.arr_we_b) arr_mem[bus.arr_addr_b] <= bus.arr_data_b;
    end

    // Scoreboard queues
    logic [TW+IW:0]  exp_req[$];
    logic [DW-1:0]   exp_wd[$];
    logic [IW+LW-1:0] exp_line[$];
    int              exp_we_cyc[$];
    int              exp_done[$];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    logic           prev_req_stall;
    logic [TW+IW:0] prev_req;
    logic           prev_w_stall;
    logic [DW-1:0]  prev_wdata;
    always @(negedge clk) begin
        if (rst) begin
            prev_req_stall <= 1'b0;
            prev_w_stall   <= 1'b0;
        end else begin
            if (prev_req_stall)
                check("req_hold", {bus.mem_req_valid, bus.mem_req_write, bus.mem_req_addr}, {1'b1, prev_req});
            if (prev_w_stall)
                check("wdata_hold", {bus.mem_wvalid, bus.mem_wdata}, {1'b1, prev_wdata});
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                if (exp_req.size() == 0) check("req_unexpected", exp_req.size(), 1);
                else check("mem_req", {bus.mem_req_write, bus.mem_req_addr}, exp_req.pop_front());
            end
            if (bus.mem_wvalid && bus.mem_wready) begin
                if (exp_wd.size() == 0) check("wbeat_unexpected", exp_wd.size(), 1);
                else check("wdata", bus.mem_wdata, exp_wd.pop_front());
            end
            if (bus.arr_we_b) begin
                if (exp_line.size() == 0) check("arr_we_unexpected", exp_line.size(), 1);
                else begin
                    check("arr_line", {bus.arr_addr_b, bus.arr_data_b}, exp_line.pop_front());
                    check("arr_we_cycle", cyc, exp_we_cyc.pop_front());
                end
            end
            if (bus.done) begin
                if (exp_done.size() == 0) check("done_unexpected", exp_done.size(), 1);
                else check("done_cycle", cyc, exp_done.pop_front());
            end
            prev_req_stall <= bus.mem_req_valid && !bus.mem_req_ready;
            prev_req       <= {bus.mem_req_write, bus.mem_req_addr};
            prev_w_stall   <= bus.mem_wvalid && !bus.mem_wready;
            prev_wdata     <= bus.mem_wdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_ready"}, bus.miss_ready, 1);
        check({name, "_outs"}, {bus.arr_we_b, bus.done, bus.mem_req_valid, bus.mem_req_write,
              bus.mem_wvalid, bus.arr_addr_b, bus.mem_req_addr, bus.mem_wdata, bus.arr_data_b}, 0);
    endtask

    task automatic start_miss(input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                              input logic dirty, input logic [TW-1:0] vtag);
        int n = 0;
        while (!bus.miss_ready && n < 100) begin step(); n++; end
        check("miss_ready_wait", bus.miss_ready, 1);
        bus.miss_valid   = 1'b1;
        bus.miss_index   = idx;
        bus.miss_tag     = tag;
        bus.victim_dirty = dirty;
        bus.victim_tag   = vtag;
        if (dirty) begin
            exp_req.push_back({1'b1, vtag, idx});
            for (int k = 0; k < 8; k++) exp_wd.push_back(32'hA0 + k);
        end
        exp_req.push_back({1'b0, tag, idx});
        step();
        bus.miss_valid = 1'b0;
    endtask

    task automatic accept_req(input int delay, input logic noise);
        int n = 0;
        while (!bus.mem_req_valid && n < 100) begin step(); n++; end
        check("req_wait", bus.mem_req_valid, 1);
        repeat (delay) begin
            if (noise) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = 32'hDEAD_BEEF;
            end
            step();
        end
        bus.mem_rvalid    = 1'b0;
        bus.mem_rdata     = '0;
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
    endtask

    task automatic wb_beats();
        int  n = 0;
        int  g = 0;
        logic w = 1'b1;
        while (n < 8 && g < 100) begin
            bus.mem_wready = w;
            if (bus.mem_wvalid && w) n++;
            step();
            w = !w;
            g++;
        end
        bus.mem_wready = 1'b0;
        check("wb_beat_count", n, 8);
    endtask

    // Returns in the cycle after the last beat
    task automatic fill_beats(input logic [IW-1:0] idx, input logic [DW-1:0] base, input logic gaps);
        logic [LW-1:0] line = '0;
        for (int k = 0; k < 8; k++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = base + DW'(k);
            line[k*DW +: DW] = base + DW'(k);
            if (k == 7) begin
                exp_line.push_back({idx, line});
                exp_we_cyc.push_back(cyc + 1);
                exp_done.push_back(cyc + 2);
            end
            step();
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = '0;
            if (gaps && k != 7) repeat (2) step();
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!bus.miss_ready && n < 100) begin step(); n++; end
        check("idle_wait", bus.miss_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 512; i++) arr_mem[i] = '0;
        for (int k = 0; k < 8; k++) arr_mem[7][k*DW +: DW] = 32'hA0 + k;
        bus.miss_valid = 0; bus.miss_index = 0; bus.miss_tag = 0;
        bus.victim_dirty = 0; bus.victim_tag = 0;
        bus.mem_req_ready = 0; bus.mem_wready = 0; bus.mem_rdata = 0; bus.mem_rvalid = 0;

        repeat (3) step();
        check_idle_outputs("reset");
        rst = 1'b0;
        step();

        // 1: clean miss
        start_miss(9'h05, 20'hABCDE, 1'b0, 20'h0);
        accept_req(0, 1'b0);
        fill_beats(9'h05, 32'h100, 1'b0);
        step();
        check("t1_ready_at_done", bus.miss_ready, 0);
        step();
        check("t1_ready_t3", bus.miss_ready, 1);

        // 2: dirty miss, writeback with wready toggling
        start_miss(9'h07, 20'h12345, 1'b1, 20'h00011);
        accept_req(0, 1'b0);
        wb_beats();
        accept_req(0, 1'b0);
        fill_beats(9'h07, 32'h200, 1'b0);
        wait_idle();

        // 3: max index, delayed accept with stray rvalid, gapped fill, stray wready
        start_miss(9'h1FF, 20'hFFFFF, 1'b0, 20'h0);
        bus.mem_wready = 1'b1;
        accept_req(3, 1'b1);
        fill_beats(9'h1FF, 32'h300, 1'b1);
        bus.mem_wready = 1'b0;
        wait_idle();

        // 4: reset after 4 fill beats, then a normal miss
        start_miss(9'h10, 20'h00001, 1'b0, 20'h0);
        accept_req(0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'hEE00 + k;
            step();
        end
        bus.mem_rvalid = 1'b0;
        rst = 1'b1;
        step();
        check_idle_outputs("abort");
        rst = 1'b0;
        repeat (4) step();
        check_idle_outputs("abort_settled");
        start_miss(9'h10, 20'h00002, 1'b0, 20'h0);
        accept_req(0, 1'b0);
        fill_beats(9'h10, 32'h400, 1'b0);
        wait_idle();

        // 5: miss_valid held while busy, then a back-to-back second miss
        bus.miss_valid = 1'b1;
        bus.miss_index = 9'h20; bus.miss_tag = 20'h55555; bus.victim_dirty = 1'b0;
        exp_req.push_back({1'b0, 20'h55555, 9'h20});
        step();
        bus.miss_index = 9'h21; bus.miss_tag = 20'h66666;
        check("t5_busy_ready", bus.miss_ready, 0);
        accept_req(0, 1'b0);
        fill_beats(9'h20, 32'h500, 1'b0);
        check("t5_ready_we", bus.miss_ready, 0);
        step();
        check("t5_ready_done", bus.miss_ready, 0);
        step();
        check("t5_ready_after_done", bus.miss_ready, 1);
        exp_req.push_back({1'b0, 20'h66666, 9'h21});
        step();
        bus.miss_valid = 1'b0;
        check("t5_second_busy", bus.miss_ready, 0);
        accept_req(0, 1'b0);
        fill_beats(9'h21, 32'h600, 1'b0);
        wait_idle();

        repeat (5) step();
        check("left_req", exp_req.size(), 0);
        check("left_wdata", exp_wd.size(), 0);
        check("left_line", exp_line.size(), 0);
        check("left_done", exp_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
